// File: rtl/cpu7_wb_arbiter_if.sv
// Result-source and write-back bundle around cpu7_wb_arbiter.
// The master side is the execute pipes; the slave side is the arbiter.
interface cpu7_wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              flush;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_pc;
  logic              req0_wen;
  logic [4:0]        req0_wnum;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_pc;
  logic              req1_wen;
  logic [4:0]        req1_wnum;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;

  logic              req2_valid;
  logic [DATA_W-1:0] req2_pc;
  logic              req2_wen;
  logic [4:0]        req2_wnum;
  logic [DATA_W-1:0] req2_wdata;
  logic              req2_ready;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_pc;
  logic              wb_rf_wen;
  logic [4:0]        wb_rf_wnum;
  logic [DATA_W-1:0] wb_rf_wdata;
  logic [1:0]        last_grant;

  modport master (
    output flush,
    output req0_valid, req0_pc, req0_wen, req0_wnum, req0_wdata,
    output req1_valid, req1_pc, req1_wen, req1_wnum, req1_wdata,
    output req2_valid, req2_pc, req2_wen, req2_wnum, req2_wdata,
    input  req0_ready, req1_ready, req2_ready,
    input  wb_valid, wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata, last_grant
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_pc, req0_wen, req0_wnum, req0_wdata,
    input  req1_valid, req1_pc, req1_wen, req1_wnum, req1_wdata,
    input  req2_valid, req2_pc, req2_wen, req2_wnum, req2_wdata,
    output req0_ready, req1_ready, req2_ready,
    output wb_valid, wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata, last_grant
  );
endinterface

// File: rtl/cpu7_wb_arbiter.sv
// Rotating-priority arbiter sharing the RF write port between ALU (0), LSU (1)
// and MDU (2); the winner is registered onto wb_* one cycle after its transfer.
module cpu7_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 3
) (
  input  logic             clk,
  input  logic             resetn,
  cpu7_wb_arbiter_if.slave bus
);

  logic [NREQ-1:0]   valid;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic [1:0]        ptr;
  logic [1:0]        first, second, third;
  logic [1:0]        win;
  logic              xfer;

  logic [DATA_W-1:0] sel_pc;
  logic              sel_wen;
  logic [4:0]        sel_wnum;
  logic [DATA_W-1:0] sel_wdata;

  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_pc_q;
  logic              wb_rf_wen_q;
  logic [4:0]        wb_rf_wnum_q;
  logic [DATA_W-1:0] wb_rf_wdata_q;
  logic [1:0]        last_grant_q;

  assign valid = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
  // A flush kills only the ALU result still in flight this cycle.
  assign elig  = valid & {1'b1, 1'b1, ~bus.flush};

  // Encoding 3 is unreachable; fold it onto 2 so the ALU leads the search.
  assign ptr = (last_grant_q == 2'd3) ? 2'd2 : last_grant_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    first  = 2'd0;
    second = 2'd1;
    third  = 2'd2;
    case (ptr)
      2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: ;
    endcase
  end

  always_comb begin
    win  = 2'd0;
    xfer = 1'b0;
    if (elig[first]) begin
      win  = first;
      xfer = 1'b1;
    end else if (elig[second]) begin
      win  = second;
      xfer = 1'b1;
    end else if (elig[third]) begin
      win  = third;
      xfer = 1'b1;
    end
    // Readys must stay low while reset is held, whatever the requesters show.
    if (!resetn) xfer = 1'b0;
  end

  assign grant = xfer ? (3'b001 << win) : 3'b000;

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.req2_ready = grant[2];

  always_comb begin
    sel_pc    = bus.req0_pc;
    sel_wen   = bus.req0_wen;
    sel_wnum  = bus.req0_wnum;
    sel_wdata = bus.req0_wdata;
    case (win)
      2'd1: begin
        sel_pc    = bus.req1_pc;
        sel_wen   = bus.req1_wen;
        sel_wnum  = bus.req1_wnum;
        sel_wdata = bus.req1_wdata;
      end
      2'd2: begin
        sel_pc    = bus.req2_pc;
        sel_wen   = bus.req2_wen;
        sel_wnum  = bus.req2_wnum;
        sel_wdata = bus.req2_wdata;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_rf_wen_q   <= 1'b0;
      wb_rf_wnum_q  <= '0;
      wb_rf_wdata_q <= '0;
      last_grant_q  <= 2'd2;
    end else begin
      wb_valid_q <= xfer;
      if (xfer) begin
        wb_pc_q       <= sel_pc;
        // Writes to r0 still retire but never reach the register file.
        wb_rf_wen_q   <= sel_wen & (sel_wnum != 5'd0);
        wb_rf_wnum_q  <= sel_wnum;
        wb_rf_wdata_q <= sel_wdata;
        last_grant_q  <= win;
      end else begin
        wb_rf_wen_q   <= 1'b0;
      end
    end
  end

  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_pc       = wb_pc_q;
  assign bus.wb_rf_wen   = wb_rf_wen_q;
  assign bus.wb_rf_wnum  = wb_rf_wnum_q;
  assign bus.wb_rf_wdata = wb_rf_wdata_q;
  assign bus.last_grant  = last_grant_q;

endmodule

// File: tb/tb_cpu7_wb_arbiter.sv
// Self-checking bench for cpu7_wb_arbiter: directed scenarios followed by
// randomized traffic, compared against a round-robin reference model.
module tb_cpu7_wb_arbiter;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  cpu7_wb_arbiter_if #(.DATA_W(DATA_W)) bus ();

  cpu7_wb_arbiter #(.DATA_W(DATA_W), .NREQ(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Requester state as the bench sees it.
  bit              v     [3];
  logic [31:0]     rpc   [3];
  bit              rwen  [3];
  logic [4:0]      rnum  [3];
  logic [31:0]     rdata [3];
  bit              fl;

  // Reference model: round-robin pointer plus the expected write-back register.
  int              m_ptr;
  bit              e_valid;
  logic [31:0]     e_pc;
  bit              e_wen;
  logic [4:0]      e_num;
  logic [31:0]     e_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.flush      = fl;
    bus.req0_valid = v[0]; bus.req0_pc = rpc[0]; bus.req0_wen = rwen[0];
    bus.req0_wnum  = rnum[0]; bus.req0_wdata = rdata[0];
    bus.req1_valid = v[1]; bus.req1_pc = rpc[1]; bus.req1_wen = rwen[1];
    bus.req1_wnum  = rnum[1]; bus.req1_wdata = rdata[1];
    bus.req2_valid = v[2]; bus.req2_pc = rpc[2]; bus.req2_wen = rwen[2];
    bus.req2_wnum  = rnum[2]; bus.req2_wdata = rdata[2];
  endtask

  task automatic set_req(input int n, input logic [31:0] pc, input bit wen,
                         input logic [4:0] num, input logic [31:0] data);
    v[n] = 1'b1; rpc[n] = pc; rwen[n] = wen; rnum[n] = num; rdata[n] = data;
  endtask

  task automatic rand_req(input int n);
    set_req(n, 32'h1c00_0000 + ($urandom_range(0, 4095) << 2), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), $urandom);
  endtask

  function automatic int model_pick();
    int idx;
    for (int k = 1; k <= 3; k++) begin
      idx = (m_ptr + k) % 3;
      if (v[idx] && !(idx == 0 && fl)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2:0] ready_mask();
    return {bus.req2_ready, bus.req1_ready, bus.req0_ready};
  endfunction

  task automatic model_reset();
    m_ptr = 2; e_valid = 0; e_pc = '0; e_wen = 0; e_num = '0; e_data = '0;
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'(e_valid));
    check({tag, "_wb_pc"},    64'(bus.wb_pc), 64'(e_pc));
    check({tag, "_wb_wen"},   64'(bus.wb_rf_wen), 64'(e_wen));
    check({tag, "_wb_wnum"},  64'(bus.wb_rf_wnum), 64'(e_num));
    check({tag, "_wb_wdata"}, 64'(bus.wb_rf_wdata), 64'(e_data));
  endtask

  // One cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input string tag, output int w);
    drive();
    #2;
    w = model_pick();
    check({tag, "_ready"}, 64'(ready_mask()), (w < 0) ? 64'd0 : 64'(3'b001 << w));
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_ptr   = w;
      e_valid = 1;
      e_pc    = rpc[w];
      e_num   = rnum[w];
      e_data  = rdata[w];
      e_wen   = rwen[w] && (rnum[w] != 5'd0);
    end else begin
      e_valid = 0;
      e_wen   = 0;
    end
    check_wb(tag);
    check({tag, "_last_grant"}, 64'(bus.last_grant), 64'(m_ptr));
  endtask

  // Asserts reset between edges, checks the asynchronous clear, and
  // releases it 1 time unit after a later edge.
  task automatic apply_reset(input string tag);
    drive();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_wb(tag);
    check({tag, "_ready"}, 64'(ready_mask()), 64'd0);
    check({tag, "_last_grant"}, 64'(bus.last_grant), 64'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 3; i++) begin
      v[i] = 0; rpc[i] = '0; rwen[i] = 0; rnum[i] = '0; rdata[i] = '0;
    end
    fl = 0;
  endtask

  initial begin
    int w;
    clear_reqs();
    model_reset();
    drive();
    @(posedge clk);
    #1;
    apply_reset("reset");

    // Lone ALU result.
    set_req(0, 32'h1c00_0000, 1'b1, 5'd4, 32'h55);
    step("t1", w);
    check("t1_grant", 64'(w), 64'd0);
    check("t1_wdata", 64'(bus.wb_rf_wdata), 64'h55);
    v[0] = 0;

    // Continuous contention right after reset.
    apply_reset("t2_rst");
    for (int i = 0; i < 3; i++) set_req(i, 32'h1c00_1000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'(i + 100));
    for (int k = 0; k < 6; k++) begin
      step("t2", w);
      check("t2_order", 64'(w), 64'(k % 3));
      check("t2_wb_valid", 64'(bus.wb_valid), 64'd1);
      if (w >= 0) rand_req(w);
    end
    clear_reqs();

    // r0 destination retires without writing.
    set_req(1, 32'h1c00_0100, 1'b1, 5'd0, 32'hdead);
    step("t3", w);
    check("t3_wen", 64'(bus.wb_rf_wen), 64'd0);
    check("t3_pc", 64'(bus.wb_pc), 64'h1c00_0100);
    check("t3_valid", 64'(bus.wb_valid), 64'd1);
    v[1] = 0;

    // Flush masks the ALU only.
    apply_reset("t4_rst");
    set_req(0, 32'h1c00_0200, 1'b1, 5'd7, 32'h77);
    set_req(2, 32'h1c00_0204, 1'b1, 5'd8, 32'h88);
    fl = 1;
    step("t4a", w);
    check("t4_grant_mdu", 64'(w), 64'd2);
    v[2] = 0;
    step("t4b", w);
    check("t4_no_grant", 64'(w), 64'hffff_ffff_ffff_ffff);
    check("t4_no_wb", 64'(bus.wb_valid), 64'd0);
    check("t4_lg_hold", 64'(bus.last_grant), 64'd2);
    clear_reqs();

    // Reset mid-stream with a pending LSU result.
    set_req(1, 32'h1c00_0300, 1'b1, 5'd9, 32'h99);
    step("t5a", w);
    set_req(1, 32'h1c00_0304, 1'b1, 5'd10, 32'haa);
    apply_reset("t5_rst");
    step("t5b", w);
    check("t5_lsu_first", 64'(w), 64'd1);
    set_req(1, 32'h1c00_0308, 1'b1, 5'd11, 32'hbb);
    apply_reset("t5_rst2");
    set_req(0, 32'h1c00_030c, 1'b1, 5'd12, 32'hcc);
    step("t5c", w);
    check("t5_alu_first", 64'(w), 64'd0);
    clear_reqs();

    // Idle cycles hold the data, drop valid and wen.
    step("t6a", w);
    step("t6b", w);
    check("t6_wdata_hold", 64'(bus.wb_rf_wdata), 64'hcc);
    check("t6_wen", 64'(bus.wb_rf_wen), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 59) == 0) apply_reset("rnd_rst");
      step("rnd", w);
      if (w >= 0) v[w] = 0;
      for (int i = 0; i < 3; i++)
        if (!v[i] && $urandom_range(0, 3) != 0) rand_req(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
